relogio_ajuste_ctrl: RTL and testbench

Adjust-mode controller for the HH:MM:SS clock. Consumes the debounced mode/inc/dec button levels and sequences the time-counter datapath: selects which field is being adjusted, gates normal 1 Hz counting, and issues single-step increment/decrement commands over a valid/ready handshake. Supports auto-repeat while a button is held and an inactivity timeout back to run mode. Sits between the debouncers and the seconds/minutes/hours counters.

---
 rtl/relogio_pkg.sv | 31 +++
 rtl/relogio_btn_repeat.sv | 80 ++++++++
 rtl/relogio_ajuste_ctrl.sv | 157 +++++++++++++++
 tb/tb_relogio_ajuste_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/relogio_pkg.sv
// Shared types for the HH:MM:SS clock: adjust-mode encoding, step direction
// constants and small helpers used by the adjust controller and time counters.
package relogio_pkg;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      AJ_SEG  = 2'd1,
      AJ_MIN  = 2'd2,
      AJ_HORA = 2'd3
   } modo_t;

   localparam logic CMD_INC = 1'b1;
   localparam logic CMD_DEC = 1'b0;

   // Mode button cycles through the adjust fields and wraps back to RUN.
   function automatic modo_t next_modo(input modo_t m);
      modo_t r;
      case (m)
         RUN:     r = AJ_SEG;
         AJ_SEG:  r = AJ_MIN;
         AJ_MIN:  r = AJ_HORA;
         default: r = RUN;
      endcase
      return r;
   endfunction

   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/relogio_btn_repeat.sv
// Rising-edge detector for one debounced button plus, when RELOGIO_AUTOREPEAT_EN
// is defined, the hold/repeat timer that emits auto-repeat step pulses.
module relogio_btn_repeat
   import relogio_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES   = 50_000_000,
   parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic i_btn,
   input  logic i_arm,
   input  logic i_cancel,
   output logic o_rise,
   output logic o_step
);

   logic r_prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_prev <= 1'b0;
      end else begin
         r_prev <= i_btn;
      end
   end

   assign o_rise = i_btn & ~r_prev;

`ifdef RELOGIO_AUTOREPEAT_EN

   localparam int unsigned CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int unsigned CW      = cnt_width(CNT_MAX);
   localparam logic [CW-1:0] HOLD_LAST = CW'((HOLD_CYCLES   == 0) ? 0 : HOLD_CYCLES   - 1);
   localparam logic [CW-1:0] REP_LAST  = CW'((REPEAT_CYCLES == 0) ? 0 : REPEAT_CYCLES - 1);

   logic          r_armed;
   logic          r_repeating;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_last;
   logic          w_hit;

   assign w_last = r_repeating ? REP_LAST : HOLD_LAST;
   assign w_hit  = r_armed & i_btn & (r_cnt == w_last);
   assign o_step = w_hit;

   // The first period after a press is HOLD, every later one is REPEAT;
   // letting go or a cancel from the controller drops the timer at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_armed     <= 1'b0;
         r_repeating <= 1'b0;
         r_cnt       <= '0;
      end else if (i_arm) begin
         r_armed     <= 1'b1;
         r_repeating <= 1'b0;
         r_cnt       <= '0;
      end else if (i_cancel || !i_btn) begin
         r_armed     <= 1'b0;
         r_repeating <= 1'b0;
         r_cnt       <= '0;
      end else if (r_armed) begin
         if (w_hit) begin
            r_cnt       <= '0;
            r_repeating <= 1'b1;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

`else

   logic w_unused_cfg;
   assign w_unused_cfg = ^{i_arm, i_cancel, HOLD_CYCLES[0], REPEAT_CYCLES[0]};
   assign o_step       = 1'b0;

`endif

endmodule

// File: rtl/relogio_ajuste_ctrl.sv
// Adjust-mode controller for the HH:MM:SS clock: mode FSM, step command
// handshake and inactivity timeout. Auto-repeat built with RELOGIO_AUTOREPEAT_EN.
module relogio_ajuste_ctrl
   import relogio_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES    = 50_000_000,
   parameter int unsigned REPEAT_CYCLES  = 10_000_000,
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000_000
) (
   input  logic       clk_100MHz,
   input  logic       rst,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic       btn_dec,
   input  logic       cmd_ready,
   output logic [1:0] modo_ajuste,
   output logic       run_en,
   output logic       cmd_valid,
   output logic [1:0] cmd_field,
   output logic       cmd_dir
);

   localparam bit              TO_EN   = (TIMEOUT_CYCLES != 0);
   localparam int unsigned     TO_W    = cnt_width(TIMEOUT_CYCLES);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

   modo_t           r_state;
   modo_t           w_state_next;
   logic            r_mode_prev;
   logic [TO_W-1:0] r_to_cnt;
   logic            r_cmd_valid;
   logic [1:0]      r_cmd_field;
   logic            r_cmd_dir;

   logic w_mode_rise;
   logic w_inc_rise;
   logic w_dec_rise;
   logic w_inc_step;
   logic w_dec_step;
   logic w_adjust;
   logic w_inc_press;
   logic w_dec_press;
   logic w_rep_ok;
   logic w_inc_rep;
   logic w_dec_rep;
   logic w_issue;
   logic w_issue_dir;
   logic w_activity;
   logic w_timeout;
   logic w_cancel_all;
   logic w_cancel_inc;
   logic w_cancel_dec;

   always_ff @(posedge clk_100MHz or posedge rst) begin
      if (rst) begin
         r_mode_prev <= 1'b0;
      end else begin
         r_mode_prev <= btn_mode;
      end
   end

   assign w_mode_rise = btn_mode & ~r_mode_prev;
   assign w_adjust    = (r_state != RUN);

   // Mode edge wins over a step in the same cycle; inc wins over dec.
   assign w_inc_press = w_adjust & w_inc_rise & ~w_mode_rise;
   assign w_dec_press = w_adjust & w_dec_rise & ~w_inc_rise & ~w_mode_rise;
   assign w_rep_ok    = w_adjust & ~w_mode_rise & ~w_inc_press & ~w_dec_press;
   assign w_inc_rep   = w_rep_ok & w_inc_step;
   assign w_dec_rep   = w_rep_ok & w_dec_step & ~w_inc_step;
   assign w_issue     = w_inc_press | w_dec_press | w_inc_rep | w_dec_rep;
   assign w_issue_dir = (w_inc_press | w_inc_rep) ? CMD_INC : CMD_DEC;

   assign w_activity = w_mode_rise | w_inc_rise | w_dec_rise | w_inc_step | w_dec_step;
   assign w_timeout  = TO_EN & w_adjust & ~w_activity & (r_to_cnt == TO_LAST);

   // A new press hands auto-repeat over to the button that won it.
   assign w_cancel_all = w_mode_rise | ~w_adjust | w_timeout;
   assign w_cancel_inc = w_cancel_all | w_dec_press;
   assign w_cancel_dec = w_cancel_all | w_inc_press;

   relogio_btn_repeat #(
      .HOLD_CYCLES   (HOLD_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES)
   ) u_rep_inc (
      .clk      (clk_100MHz),
      .rst      (rst),
      .i_btn    (btn_inc),
      .i_arm    (w_inc_press),
      .i_cancel (w_cancel_inc),
      .o_rise   (w_inc_rise),
      .o_step   (w_inc_step)
   );

   relogio_btn_repeat #(
      .HOLD_CYCLES   (HOLD_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES)
   ) u_rep_dec (
      .clk      (clk_100MHz),
      .rst      (rst),
      .i_btn    (btn_dec),
      .i_arm    (w_dec_press),
      .i_cancel (w_cancel_dec),
      .o_rise   (w_dec_rise),
      .o_step   (w_dec_step)
   );

   always_ff @(posedge clk_100MHz or posedge rst) begin
      if (rst) begin
         r_state <= RUN;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      if (w_timeout) begin
         w_state_next = RUN;
      end else if (w_mode_rise) begin
         w_state_next = next_modo(r_state);
      end
   end

   // Saturates at the terminal count; the timeout itself returns us to RUN.
   always_ff @(posedge clk_100MHz or posedge rst) begin
      if (rst) begin
         r_to_cnt <= '0;
      end else if (!w_adjust || w_activity) begin
         r_to_cnt <= '0;
      end else if (r_to_cnt != TO_LAST) begin
         r_to_cnt <= r_to_cnt + 1'b1;
      end
   end

   // Single-entry command slot: a step arriving while the slot is stalled is lost.
   always_ff @(posedge clk_100MHz or posedge rst) begin
      if (rst) begin
         r_cmd_valid <= 1'b0;
         r_cmd_field <= 2'd0;
         r_cmd_dir   <= 1'b0;
      end else if (w_issue && (!r_cmd_valid || cmd_ready)) begin
         r_cmd_valid <= 1'b1;
         r_cmd_field <= r_state;
         r_cmd_dir   <= w_issue_dir;
      end else if (r_cmd_valid && cmd_ready) begin
         r_cmd_valid <= 1'b0;
      end
   end

   assign modo_ajuste = r_state;
   assign run_en      = (r_state == RUN);
   assign cmd_valid   = r_cmd_valid;
   assign cmd_field   = r_cmd_field;
   assign cmd_dir     = r_cmd_dir;

endmodule

// File: tb/tb_relogio_ajuste_ctrl.sv
// Directed bench for relogio_ajuste_ctrl: vector table for mode cycling and taps,
// plus hand sequences for stall/drop, hold auto-repeat, timeout and reset.
module tb_relogio_ajuste_ctrl;

   logic       clk;
   logic       rst;
   logic       btnMode;
   logic       btnInc;
   logic       btnDec;
   logic       cmdReady;
   logic [1:0] modoAjuste;
   logic       runEn;
   logic       cmdValid;
   logic [1:0] cmdField;
   logic       cmdDir;

   int nVectors     = 0;
   int nMiscompares = 0;

   typedef struct {
      logic       mode;
      logic       inc;
      logic       dec;
      logic       ready;
      logic [1:0] expModo;
      logic       expRun;
      logic       expValid;
      logic [1:0] expField;
      logic       expDir;
   } vec_t;

   vec_t vecs [22];

   relogio_ajuste_ctrl #(
      .HOLD_CYCLES    (8),
      .REPEAT_CYCLES  (4),
      .TIMEOUT_CYCLES (64)
   ) dut (
      .clk_100MHz  (clk),
      .rst         (rst),
      .btn_mode    (btnMode),
      .btn_inc     (btnInc),
      .btn_dec     (btnDec),
      .cmd_ready   (cmdReady),
      .modo_ajuste (modoAjuste),
      .run_en      (runEn),
      .cmd_valid   (cmdValid),
      .cmd_field   (cmdField),
      .cmd_dir     (cmdDir)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic stepClock();
      @(posedge clk);
      #1;
   endtask

   task automatic stepClocks(input int n);
      for (int k = 0; k < n; k++) stepClock();
   endtask

   task automatic applyStimulus(input logic m, input logic i, input logic d, input logic r);
      btnMode  = m;
      btnInc   = i;
      btnDec   = d;
      cmdReady = r;
      stepClock();
   endtask

   task automatic checkOutput(input string name, input logic [1:0] expModo, input logic expRun,
                              input logic expValid, input logic chkCmd,
                              input logic [1:0] expField, input logic expDir);
      nVectors++;
      if (modoAjuste !== expModo || runEn !== expRun || cmdValid !== expValid ||
          (chkCmd && (cmdField !== expField || cmdDir !== expDir))) begin
         nMiscompares++;
         $display("[TB] FAIL %s: got modo=%0d run=%0b valid=%0b field=%0d dir=%0b, want modo=%0d run=%0b valid=%0b field=%0d dir=%0b",
                  name, modoAjuste, runEn, cmdValid, cmdField, cmdDir,
                  expModo, expRun, expValid, expField, expDir);
      end
   endtask

   task automatic pressMode();
      applyStimulus(1'b1, 1'b0, 1'b0, cmdReady);
      applyStimulus(1'b0, 1'b0, 1'b0, cmdReady);
   endtask

   initial begin
      bit isStep;

      //            mode inc dec rdy  modo run valid field dir
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 2'd0, 1'b0};
      vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 2'd0, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 2'd0, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 2'd0, 1'b0};
      vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 2'd0, 1'b0};
      vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 2'd0, 1'b0};
      vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0};
      vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0};
      vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0};
      vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0};
      vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 2'd0, 1'b0};
      vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 2'd0, 1'b0};
      vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 2'd0, 1'b0};
      vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 2'd0, 1'b0};
      vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 2'd2, 1'b1};
      vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 2'd0, 1'b0};
      vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 2'd0, 1'b0};
      vecs[17] = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 2'd2, 1'b1};
      vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 2'd2, 1'b1};
      vecs[19] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 2'd0, 1'b0};
      vecs[20] = '{1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 2'd0, 1'b0};
      vecs[21] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 2'd0, 1'b0};

      rst      = 1'b1;
      btnMode  = 1'b0;
      btnInc   = 1'b0;
      btnDec   = 1'b0;
      cmdReady = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset", 2'd0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0);
      rst = 1'b0;

      for (int i = 0; i < 22; i++) begin
         applyStimulus(vecs[i].mode, vecs[i].inc, vecs[i].dec, vecs[i].ready);
         checkOutput($sformatf("vec%0d", i), vecs[i].expModo, vecs[i].expRun,
                     vecs[i].expValid, vecs[i].expValid, vecs[i].expField, vecs[i].expDir);
      end

      // Stalled slot: dec captured, later inc dropped, one acceptance.
      pressMode();
      checkOutput("stallToRun", 2'd0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
      pressMode();
      checkOutput("stallSeg", 2'd1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("stallDec", 2'd1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("stallIncDropped", 2'd1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("stallAccept", 2'd1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         stepClock();
         checkOutput($sformatf("stallNoSecond%0d", k), 2'd1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
      end

      // Hold inc in AJ_HORA for 20 cycles after the press.
      pressMode();
      pressMode();
      checkOutput("holdHora", 2'd3, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
      checkOutput("holdPress", 2'd3, 1'b0, 1'b1, 1'b1, 2'd3, 1'b1);
      for (int k = 1; k <= 20; k++) begin
         stepClock();
`ifdef RELOGIO_AUTOREPEAT_EN
         isStep = (k == 8) || (k == 12) || (k == 16) || (k == 20);
`else
         isStep = 1'b0;
`endif
         checkOutput($sformatf("hold+%0d", k), 2'd3, 1'b0, isStep, isStep, 2'd3, 1'b1);
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("holdRelease", 2'd3, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
      stepClocks(5);
      checkOutput("holdAfter", 2'd3, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);

      // Inactivity timeout from AJ_SEG, then restart by a press at cycle 63.
      pressMode();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      checkOutput("toEnter", 2'd1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
      btnMode = 1'b0;
      stepClocks(62);
      stepClock();
      checkOutput("toEdge63", 2'd1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
      stepClock();
      checkOutput("toEdge64", 2'd0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      checkOutput("toReenter", 2'd1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
      btnMode = 1'b0;
      stepClocks(62);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
      checkOutput("toPress63", 2'd1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("toRestart64", 2'd1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
      stepClocks(62);
      checkOutput("toRestart126", 2'd1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
      stepClock();
      checkOutput("toRestart127", 2'd0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);

      // Reset mid-hold with a command pending.
      pressMode();
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("rstPending", 2'd1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1);
      stepClocks(3);
      #3;
      rst = 1'b1;
      #1;
      checkOutput("rstAsync", 2'd0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0);
      @(posedge clk);
      #1;
      rst      = 1'b0;
      cmdReady = 1'b1;
      stepClocks(12);
      checkOutput("rstHeldRun", 2'd0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
      stepClocks(10);
      checkOutput("rstHeldNoStep", 2'd1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
      checkOutput("rstNewPress", 2'd1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("rstNewDone", 2'd1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule
